ex_muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/ex_muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_iter_datapath.sv | 64 ++++++
 rtl/ex_muldiv_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, FUNC3 encodings and FSM state type for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned Xlen = 32;
  localparam int unsigned Iter = 32;

  localparam logic [2:0] Func3Mul    = 3'd0;
  localparam logic [2:0] Func3Mulh   = 3'd1;
  localparam logic [2:0] Func3Mulhsu = 3'd2;
  localparam logic [2:0] Func3Mulhu  = 3'd3;
  localparam logic [2:0] Func3Div    = 3'd4;
  localparam logic [2:0] Func3Divu   = 3'd5;
  localparam logic [2:0] Func3Rem    = 3'd6;
  localparam logic [2:0] Func3Remu   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  function automatic logic a_is_signed(input logic [2:0] f);
    return f inside {Func3Mul, Func3Mulh, Func3Mulhsu, Func3Div, Func3Rem};
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return f inside {Func3Mul, Func3Mulh, Func3Div, Func3Rem};
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline (master) and the mul/div sequencer (slave).
interface ex_muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int unsigned Width = Xlen
) ();

  logic             START;
  logic [2:0]       FUNC3;
  logic [Width-1:0] OPERAND_A;
  logic [Width-1:0] OPERAND_B;
  logic             HOLD;
  logic             FLUSH;
  logic             STALL;
  logic             DONE;
  logic [Width-1:0] RESULT;

  modport master (
    output START, FUNC3, OPERAND_A, OPERAND_B, HOLD, FLUSH,
    input  STALL, DONE, RESULT
  );

  modport slave (
    input  START, FUNC3, OPERAND_A, OPERAND_B, HOLD, FLUSH,
    output STALL, DONE, RESULT
  );

endinterface

// File: rtl/muldiv_iter_datapath.sv
// Shared shift-add multiply / restoring divide datapath; one iteration per step.
// Multiply: {hi,lo} is the product accumulator. Divide: hi is remainder, lo is quotient.
module muldiv_iter_datapath #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_mode_i,
  input  logic [Width-1:0] a_mag_i,
  input  logic [Width-1:0] b_mag_i,
  output logic [Width-1:0] hi_next_o,
  output logic [Width-1:0] lo_next_o
);

  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [Width:0]   shifted, add_x, add_y, add_res, mul_sel;
  logic             div_ge;

  always_comb begin
    shifted = {hi_q, lo_q[Width-1]};
    // One adder serves both modes: add for multiply, subtract (invert + carry-in) for divide.
    add_x   = div_mode_i ? {1'b0, shifted[Width-1:0]} : {1'b0, hi_q};
    add_y   = div_mode_i ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    add_res = add_x + add_y + {{Width{1'b0}}, div_mode_i};
    // A set shift-out bit means the partial remainder already exceeds any divisor.
    div_ge  = shifted[Width] | ~add_res[Width];
    mul_sel = lo_q[0] ? add_res : {1'b0, hi_q};

    if (div_mode_i) begin
      hi_next_o = div_ge ? add_res[Width-1:0] : shifted[Width-1:0];
      lo_next_o = {lo_q[Width-2:0], div_ge};
    end else begin
      hi_next_o = mul_sel[Width:1];
      lo_next_o = {mul_sel[0], lo_q[Width-1:1]};
    end

    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = div_mode_i ? a_mag_i : b_mag_i;
      opnd_d = div_mode_i ? b_mag_i : a_mag_i;
    end else if (step_i) begin
      hi_d = hi_next_o;
      lo_d = lo_next_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, special-case detect,
// sign fixup and the registered RESULT presented to the EX result mux.
module ex_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = Xlen,
  parameter int unsigned ITER = Iter
) (
  input logic                  CLK,
  input logic                  RESET,
  ex_muldiv_sequencer_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic              load, step, div_mode;
  logic [XLEN-1:0]   hi_next, lo_next, div_raw, calc_res;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    a_neg    = a_is_signed(bus.FUNC3) & bus.OPERAND_A[XLEN-1];
    b_neg    = b_is_signed(bus.FUNC3) & bus.OPERAND_B[XLEN-1];
    a_mag    = a_neg ? -bus.OPERAND_A : bus.OPERAND_A;
    b_mag    = b_neg ? -bus.OPERAND_B : bus.OPERAND_B;
    is_div   = bus.FUNC3[2];
    div_zero = is_div & (bus.OPERAND_B == '0);
    div_ovf  = is_div & ~bus.FUNC3[0] & (bus.OPERAND_A == MinNeg) & (bus.OPERAND_B == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = bus.FUNC3[1] ? bus.OPERAND_A : '1;
    end else begin
      special_res = bus.FUNC3[1] ? '0 : MinNeg;
    end
  end

  // Final result is taken from the last iteration's combinational output.
  always_comb begin
    prod_fix = neg_q ? -{hi_next, lo_next} : {hi_next, lo_next};
    div_raw  = func3_q[1] ? hi_next : lo_next;
    if (func3_q[2]) begin
      calc_res = neg_q ? -div_raw : div_raw;
    end else if (func3_q == Func3Mul) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    neg_d    = neg_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.START && !bus.FLUSH) begin
          load    = 1'b1;
          func3_d = bus.FUNC3;
          neg_d   = (is_div & bus.FUNC3[1]) ? a_neg : (a_neg ^ b_neg);
          if (special) begin
            state_d  = StDone;
            result_d = special_res;
          end else begin
            state_d = StCalc;
            cnt_d   = CntLast;
          end
        end
      end
      StCalc: begin
        if (bus.FLUSH) begin
          state_d = StIdle;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            state_d  = StDone;
            result_d = calc_res;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.FLUSH || !bus.HOLD) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign div_mode = (state_q == StIdle) ? bus.FUNC3[2] : func3_q[2];

  muldiv_iter_datapath #(
    .Width(XLEN)
  ) u_datapath (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .load_i    (load),
    .step_i    (step),
    .div_mode_i(div_mode),
    .a_mag_i   (a_mag),
    .b_mag_i   (b_mag),
    .hi_next_o (hi_next),
    .lo_next_o (lo_next)
  );

  assign bus.STALL  = ~bus.FLUSH & (((state_q == StIdle) & bus.START) | (state_q == StCalc));
  assign bus.DONE   = (state_q == StDone);
  assign bus.RESULT = result_q;

endmodule
